// File: rtl/eth_rx_frame_packer_if.sv
// Byte-wide AXI-stream carrying received frame bytes from the MAC into the packer.
interface eth_rx_frame_packer_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tuser;
   logic       tready;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_packer.sv
// Packs a byte stream little-endian into 64-bit words written into per-frame buffer slots,
// and keeps an in-order descriptor queue of committed frames for the CPU-side reader.
module eth_rx_frame_packer #(
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned SLOT_BITS = 1,
   parameter int unsigned LEN_W     = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   eth_rx_frame_packer_if.slave s,
   output logic                 mem_en,
   output logic [1:0]           mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [63:0]          mem_wdata,
   output logic                 rx_valid,
   output logic [SLOT_BITS-1:0] rx_slot,
   output logic [LEN_W-1:0]     rx_len,
   output logic                 rx_err,
   input  logic                 rx_ack,
   output logic [15:0]          drop_cnt
);

   localparam int unsigned IDX_W     = ADDR_W - SLOT_BITS;
   localparam int unsigned NSLOTS    = 2 ** SLOT_BITS;
   localparam int unsigned OCC_W     = SLOT_BITS + 1;
   localparam int unsigned CAP_BYTES = (2 ** IDX_W) * 8;

   typedef enum logic [2:0] {IDLE, RECV, DROP, FLUSH, COMMIT} state_t;

   state_t               state, state_d;
   logic [LEN_W-1:0]     len, len_d, cur_len;
   logic                 err, err_d;
   logic [63:0]          word, word_d;
   logic [2:0]           lane;
   logic                 accept, free, store, in_cap, wr_word, commit, ack_eff, drop_inc;
   logic [SLOT_BITS-1:0] wr_ptr, rd_ptr, rd_ptr_d;
   logic [OCC_W-1:0]     occ, occ_d;
   logic [LEN_W-1:0]     desc_len [NSLOTS];
   logic                 desc_err [NSLOTS];

   // Next-state, byte placement and queue bookkeeping
   always_comb begin
      state_d  = state;
      accept   = s.tvalid && s.tready;
      free     = occ < OCC_W'(NSLOTS);
      store    = 1'b0;
      commit   = 1'b0;
      drop_inc = 1'b0;
      cur_len  = len;
      unique case (state)
         IDLE: begin
            cur_len = '0;
            if (accept) begin
               if (free) begin
                  store   = 1'b1;
                  state_d = s.tlast ? FLUSH : RECV;
               end else begin
                  drop_inc = s.tlast;
                  state_d  = s.tlast ? IDLE : DROP;
               end
            end
         end
         RECV: begin
            if (accept) begin
               store = 1'b1;
               if (s.tlast) state_d = FLUSH;
            end
         end
         DROP: begin
            if (accept && s.tlast) begin
               drop_inc = 1'b1;
               state_d  = IDLE;
            end
         end
         FLUSH:   state_d = COMMIT;
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_cap  = cur_len < LEN_W'(CAP_BYTES);
      lane    = cur_len[2:0];
      word_d  = (lane == 3'd0) ? 64'd0 : word;
      word_d[{lane, 3'b000} +: 8] = s.tdata;
      wr_word = store && in_cap && ((lane == 3'd7) || s.tlast);
      len_d   = in_cap ? cur_len + LEN_W'(1) : cur_len;
      err_d   = ((state == IDLE) ? 1'b0 : err) | ~in_cap | (s.tlast & s.tuser);

      ack_eff  = rx_ack && (occ != '0);
      rd_ptr_d = ack_eff ? rd_ptr + SLOT_BITS'(1) : rd_ptr;
      occ_d    = occ + OCC_W'(commit) - OCC_W'(ack_eff);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state     <= IDLE;
         s.tready  <= 1'b1;
         len       <= '0;
         err       <= 1'b0;
         word      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 2'b00;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rx_valid  <= 1'b0;
         rx_slot   <= '0;
         rx_len    <= '0;
         rx_err    <= 1'b0;
         drop_cnt  <= '0;
         for (int unsigned i = 0; i < NSLOTS; i++) begin
            desc_len[i] <= '0;
            desc_err[i] <= 1'b0;
         end
      end else begin
         state    <= state_d;
         s.tready <= !((state_d == FLUSH) || (state_d == COMMIT));

         mem_en <= wr_word;
         mem_we <= {2{wr_word}};
         if (wr_word) begin
            mem_addr  <= {wr_ptr, cur_len[3 +: IDX_W]};
            mem_wdata <= word_d;
         end

         if (store) begin
            word <= word_d;
            len  <= len_d;
            err  <= err_d;
         end

         if (commit) begin
            desc_len[wr_ptr] <= len;
            desc_err[wr_ptr] <= err;
            wr_ptr           <= wr_ptr + SLOT_BITS'(1);
         end
         rd_ptr <= rd_ptr_d;
         occ    <= occ_d;

         // Descriptor view bypasses the table when the entry is being written this edge
         rx_valid <= occ_d != '0;
         rx_slot  <= rd_ptr_d;
         rx_len   <= (commit && (wr_ptr == rd_ptr_d)) ? len : desc_len[rd_ptr_d];
         rx_err   <= (commit && (wr_ptr == rd_ptr_d)) ? err : desc_err[rd_ptr_d];

         if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule
